// File: rtl/upsp_channel_join_if.sv
// Handshake bundle between the per-channel bicubic engines, the joiner and the AXI write controller.
// Output width depends on UPSP_JOIN_SERIALIZE_EN (one pixel per beat when defined).
interface upsp_channel_join_if #(
    parameter int NUM_CH        = 3,
    parameter int CHANNEL_WIDTH = 8,
    parameter int PIX           = 4
);
`ifdef UPSP_JOIN_SERIALIZE_EN
    localparam int OUT_W = NUM_CH * CHANNEL_WIDTH;
`else
    localparam int OUT_W = PIX * NUM_CH * CHANNEL_WIDTH;
`endif

    logic [NUM_CH-1:0]                   ch_rsp_valid;
    logic [NUM_CH-1:0]                   ch_rsp_ready;
    logic [NUM_CH*PIX*CHANNEL_WIDTH-1:0] ch_rsp_data;
    logic                                upsp_ac_wvalid;
    logic                                ac_upsp_wready;
    logic [OUT_W-1:0]                    upsp_ac_wdata;
    logic                                upsp_ac_wlast;

    modport slave (
        input  ch_rsp_valid, ch_rsp_data, ac_upsp_wready,
        output ch_rsp_ready, upsp_ac_wvalid, upsp_ac_wdata, upsp_ac_wlast
    );

    modport master (
        output ch_rsp_valid, ch_rsp_data, ac_upsp_wready,
        input  ch_rsp_ready, upsp_ac_wvalid, upsp_ac_wdata, upsp_ac_wlast
    );
endinterface

// File: rtl/upsp_channel_join.sv
// Per-channel elastic FIFOs joined into pixel-aligned output beats with an end-of-line marker.
// Define UPSP_JOIN_SERIALIZE_EN to emit one pixel per beat instead of a whole group.
module upsp_channel_join #(
    parameter int NUM_CH        = 3,
    parameter int CHANNEL_WIDTH = 8,
    parameter int PIX           = 4,
    parameter int DEPTH         = 4,
    parameter int LINE_PIXELS   = 3840
) (
    input logic                 clk,
    input logic                 rst_n,
    upsp_channel_join_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SW  = PIX * CHANNEL_WIDTH;
    localparam int PW  = NUM_CH * CHANNEL_WIDTH;
    localparam int GW  = PIX * PW;
    localparam int PCW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
`ifdef UPSP_JOIN_SERIALIZE_EN
    localparam int OUT_W = PW;
    localparam int STEP  = 1;
    localparam int SUBW  = (PIX > 1) ? $clog2(PIX) : 1;
`else
    localparam int OUT_W = GW;
    localparam int STEP  = PIX;
`endif
    localparam logic [PCW-1:0] STEP_C    = PCW'(STEP);
    // A beat is the last of its line when its first pixel index is LINE_PIXELS-STEP.
    localparam logic [PCW-1:0] BEAT_LAST = PCW'(LINE_PIXELS - STEP);
    localparam logic [AW:0]    PTR_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

    logic [SW-1:0]     mem_q  [NUM_CH][DEPTH];
    logic [AW:0]       wptr_q [NUM_CH];
    logic [AW:0]       rptr_q [NUM_CH];
    logic [SW-1:0]     head_s [NUM_CH];
    logic [NUM_CH-1:0] full_s, empty_s, push_s;
    logic [GW-1:0]     grp_s;
    logic [OUT_W-1:0]  ld_data_s;
    logic              join_s, hs_s, grp_done_s, ld_last_s;
    logic [PCW-1:0]    nb_s;

    state_e            state_q;
    logic              wvalid_q, wlast_q;
    logic [OUT_W-1:0]  wdata_q;
    logic [PCW-1:0]    pix_cnt_q;
`ifdef UPSP_JOIN_SERIALIZE_EN
    logic [GW-1:0]     grp_q;
    logic [SUBW-1:0]   sub_q;
    logic [GW-1:0]     shl_s;
    logic [PW-1:0]     nxt_pix_s;
`endif

    // FIFO status and repacking of the FIFO heads into one pixel-major group.
    always_comb begin
        full_s  = '0;
        empty_s = '0;
        push_s  = '0;
        grp_s   = '0;
        head_s  = '{default: '0};
        for (int c = 0; c < NUM_CH; c++) begin
            full_s[c]  = (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]) && (wptr_q[c][AW] != rptr_q[c][AW]);
            empty_s[c] = (wptr_q[c] == rptr_q[c]);
            push_s[c]  = bus.ch_rsp_valid[c] & ~full_s[c];
            head_s[c]  = mem_q[c][rptr_q[c][AW-1:0]];
            for (int p = 0; p < PIX; p++) begin
                grp_s[(PIX-1-p)*PW + (NUM_CH-1-c)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                    head_s[c][(PIX-1-p)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            end
        end
    end

    assign bus.ch_rsp_ready   = ~full_s;
    assign bus.upsp_ac_wvalid = wvalid_q;
    assign bus.upsp_ac_wdata  = wdata_q;
    assign bus.upsp_ac_wlast  = wlast_q;

    // Join decision and the pixel index of the beat that would be loaded next.
    always_comb begin
        hs_s = (state_q == S_FULL) && bus.ac_upsp_wready;
`ifdef UPSP_JOIN_SERIALIZE_EN
        grp_done_s = hs_s && (sub_q == SUBW'(PIX - 1));
        ld_data_s  = grp_s[GW-1 -: PW];
        shl_s      = grp_q << (PW * (int'(sub_q) + 1));
        nxt_pix_s  = shl_s[GW-1 -: PW];
`else
        grp_done_s = hs_s;
        ld_data_s  = grp_s;
`endif
        join_s = (&(~empty_s)) && ((state_q == S_EMPTY) || grp_done_s);
        if (hs_s) begin
            if (wlast_q) begin
                nb_s = '0;
            end else begin
                nb_s = pix_cnt_q + STEP_C;
            end
        end else begin
            nb_s = pix_cnt_q;
        end
        ld_last_s = (nb_s == BEAT_LAST);
    end

    // Per-channel FIFO storage and pointers; every FIFO pops on a join.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    mem_q[c][d] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_s[c]) begin
                    mem_q[c][wptr_q[c][AW-1:0]] <= bus.ch_rsp_data[c*SW +: SW];
                    wptr_q[c] <= wptr_q[c] + PTR_ONE;
                end
                if (join_s) begin
                    rptr_q[c] <= rptr_q[c] + PTR_ONE;
                end
            end
        end
    end

    // Output register state machine with registered valid/data/last and line counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            pix_cnt_q <= '0;
`ifdef UPSP_JOIN_SERIALIZE_EN
            grp_q     <= '0;
            sub_q     <= '0;
`endif
        end else begin
            pix_cnt_q <= nb_s;
            if (join_s) begin
                state_q  <= S_FULL;
                wvalid_q <= 1'b1;
                wdata_q  <= ld_data_s;
                wlast_q  <= ld_last_s;
`ifdef UPSP_JOIN_SERIALIZE_EN
                grp_q    <= grp_s;
                sub_q    <= '0;
`endif
            end else if (grp_done_s) begin
                state_q  <= S_EMPTY;
                wvalid_q <= 1'b0;
                wlast_q  <= 1'b0;
`ifdef UPSP_JOIN_SERIALIZE_EN
            end else if (hs_s) begin
                sub_q    <= sub_q + SUBW'(1);
                wdata_q  <= nxt_pix_s;
                wlast_q  <= ld_last_s;
`endif
            end
        end
    end
endmodule

// File: tb/tb_upsp_channel_join.sv
// Randomised and directed bench for upsp_channel_join against a queue-based pixel-stream model.
// Works for both the grouped build and the UPSP_JOIN_SERIALIZE_EN build.
module tb_upsp_channel_join;
    localparam int NUM_CH = 3;
    localparam int CW     = 8;
    localparam int PIX    = 4;
    localparam int DEPTH  = 4;
    localparam int LINE   = 16;
    localparam int SW     = PIX * CW;
    localparam int PW     = NUM_CH * CW;
`ifdef UPSP_JOIN_SERIALIZE_EN
    localparam int STEP = 1;
`else
    localparam int STEP = PIX;
`endif
    localparam int OUT_W = STEP * PW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    upsp_channel_join_if #(.NUM_CH(NUM_CH), .CHANNEL_WIDTH(CW), .PIX(PIX)) bus ();

    upsp_channel_join #(
        .NUM_CH(NUM_CH), .CHANNEL_WIDTH(CW), .PIX(PIX), .DEPTH(DEPTH), .LINE_PIXELS(LINE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int               chk_cnt = 0;
    int               pass_cnt = 0;
    logic [SW-1:0]    ch_q [NUM_CH][$];
    logic [PW-1:0]    pix_q [$];
    int               lcnt = 0;
    logic [NUM_CH-1:0] acc;
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data;
    logic             prev_last;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        chk_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Whenever every channel has a response queued, they form the next PIX pixels.
    function automatic void model_join();
        logic [PW-1:0] px;
        logic [SW-1:0] sl [NUM_CH];
        while (1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_q[c].size() == 0) return;
            end
            for (int c = 0; c < NUM_CH; c++) sl[c] = ch_q[c].pop_front();
            for (int p = 0; p < PIX; p++) begin
                px = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    px = (px << CW) | PW'((sl[c] >> ((PIX-1-p)*CW)) & SW'({CW{1'b1}}));
                end
                pix_q.push_back(px);
            end
        end
    endfunction

    task automatic drive(input logic [NUM_CH-1:0] v);
        bus.ch_rsp_valid = v;
        for (int c = 0; c < NUM_CH; c++) bus.ch_rsp_data[c*SW +: SW] = SW'($urandom);
    endtask

    // Called at posedge+1: record accepted pushes, check the output, then advance one clock.
    task automatic cyc();
        logic [OUT_W-1:0] expd;
        logic             expl;
        acc = bus.ch_rsp_valid & bus.ch_rsp_ready;
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc[c]) ch_q[c].push_back(bus.ch_rsp_data[c*SW +: SW]);
        end
        model_join();
        if (prev_stall) begin
            chk("hold_valid", bus.upsp_ac_wvalid, 1'b1);
            chk("hold_data", bus.upsp_ac_wdata, prev_data);
            chk("hold_last", bus.upsp_ac_wlast, prev_last);
        end
        if (bus.upsp_ac_wvalid && bus.ac_upsp_wready) begin
            if (pix_q.size() < STEP) begin
                chk("beat_unexpected", pix_q.size(), STEP);
            end else begin
                expd = '0;
                for (int s = 0; s < STEP; s++) expd = (expd << PW) | OUT_W'(pix_q.pop_front());
                expl = ((lcnt + STEP - 1) == (LINE - 1));
                lcnt = (lcnt + STEP) % LINE;
                chk("beat_data", bus.upsp_ac_wdata, expd);
                chk("beat_last", bus.upsp_ac_wlast, expl);
            end
        end
        prev_stall = bus.upsp_ac_wvalid && !bus.ac_upsp_wready;
        prev_data  = bus.upsp_ac_wdata;
        prev_last  = bus.upsp_ac_wlast;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int               sent [NUM_CH];
        int               n;
        logic [OUT_W-1:0] rgb_exp;
        logic [NUM_CH-1:0] er;

        bus.ch_rsp_valid   = '0;
        bus.ch_rsp_data    = '0;
        bus.ac_upsp_wready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wvalid", bus.upsp_ac_wvalid, 1'b0);
        chk("reset_wdata", bus.upsp_ac_wdata, '0);
        chk("reset_wlast", bus.upsp_ac_wlast, 1'b0);
        chk("reset_ready", bus.ch_rsp_ready, {NUM_CH{1'b1}});
        rst_n = 1'b1;

        // Aligned constant stream: R=0x11, G=0x22, B=0x33 in every pixel.
        bus.ac_upsp_wready = 1'b1;
        bus.ch_rsp_valid   = {NUM_CH{1'b1}};
        for (int c = 0; c < NUM_CH; c++) bus.ch_rsp_data[c*SW +: SW] = {PIX{CW'(8'h11 * (c + 1))}};
        rgb_exp = {STEP{24'h112233}};
        cyc();
        chk("latency_edge1", bus.upsp_ac_wvalid, 1'b0);
        cyc();
        chk("latency_edge2", bus.upsp_ac_wvalid, 1'b1);
        chk("aligned_pixel", bus.upsp_ac_wdata, rgb_exp);
        repeat (6) begin
            cyc();
            chk("throughput", bus.upsp_ac_wvalid, 1'b1);
        end
        bus.ch_rsp_valid = '0;
        repeat (40) cyc();
        chk("aligned_drained", pix_q.size(), 0);

        // Skew: last channel starts three cycles behind the others.
        for (int c = 0; c < NUM_CH; c++) sent[c] = 0;
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bus.ch_rsp_valid[c] = (sent[c] < 16) && ((c != NUM_CH - 1) || (t >= 3));
                bus.ch_rsp_data[c*SW +: SW] = SW'($urandom);
            end
            if (t <= 3) chk("skew_lead_ready", bus.ch_rsp_ready[NUM_CH-2:0], {(NUM_CH-1){1'b1}});
            cyc();
            for (int c = 0; c < NUM_CH; c++) if (acc[c]) sent[c]++;
            if (t == 3) chk("skew_latency1", bus.upsp_ac_wvalid, 1'b0);
            if (t == 4) chk("skew_latency2", bus.upsp_ac_wvalid, 1'b1);
        end
        for (int c = 0; c < NUM_CH; c++) chk("skew_sent", sent[c], 16);
        bus.ch_rsp_valid = '0;
        repeat (40) cyc();
        chk("skew_drained", pix_q.size(), 0);

        // Backpressure: wready low, ready must drop after DEPTH+1 groups.
        bus.ac_upsp_wready = 1'b0;
        n = 0;
        for (int t = 0; t < 8; t++) begin
            drive({NUM_CH{1'b1}});
            er = (n < DEPTH + 1) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
            chk("bp_ready", bus.ch_rsp_ready, er);
            cyc();
            if (acc[0]) n++;
        end
        repeat (2) begin
            drive({NUM_CH{1'b1}});
            cyc();
        end
        bus.ac_upsp_wready = 1'b1;
        repeat (12) begin
            drive({NUM_CH{1'b1}});
            cyc();
            chk("bp_resume", bus.upsp_ac_wvalid, 1'b1);
        end
        bus.ch_rsp_valid = '0;
        repeat (40) cyc();
        chk("bp_drained", pix_q.size(), 0);

        // Random valids, data and backpressure.
        repeat (300) begin
            for (int c = 0; c < NUM_CH; c++) bus.ch_rsp_valid[c] = ($urandom_range(0, 99) < 75);
            for (int c = 0; c < NUM_CH; c++) bus.ch_rsp_data[c*SW +: SW] = SW'($urandom);
            bus.ac_upsp_wready = ($urandom_range(0, 99) < 70);
            cyc();
        end
        bus.ch_rsp_valid   = '0;
        bus.ac_upsp_wready = 1'b1;
        repeat (60) cyc();
        chk("random_drained", pix_q.size(), 0);

        // Reset with two groups buffered: nothing stale may come out afterwards.
        bus.ac_upsp_wready = 1'b0;
        repeat (2) begin
            drive({NUM_CH{1'b1}});
            cyc();
        end
        bus.ch_rsp_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("midrst_wvalid", bus.upsp_ac_wvalid, 1'b0);
        chk("midrst_wdata", bus.upsp_ac_wdata, '0);
        chk("midrst_ready", bus.ch_rsp_ready, {NUM_CH{1'b1}});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) ch_q[c].delete();
        pix_q.delete();
        lcnt       = 0;
        prev_stall = 1'b0;
        bus.ac_upsp_wready = 1'b1;
        repeat (5) begin
            cyc();
            chk("no_stale_beat", bus.upsp_ac_wvalid, 1'b0);
        end
        repeat (LINE / PIX + 2) begin
            drive({NUM_CH{1'b1}});
            cyc();
        end
        bus.ch_rsp_valid = '0;
        repeat (40) cyc();
        chk("post_reset_drained", pix_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
